snd_au_stream: RTL and testbench
================================

SND_AU_STREAM -- requirements
Module: snd_au_stream

Interface
REQ-001 SHALL have parameter CHANNELS, default 2, meaning interleaved channel count (1..8).
REQ-002 SHALL have parameter SAMPLE_BITS, default 16, meaning output sample width (8 or 16 only).
REQ-003 SHALL have parameter IN_W, default 4, meaning input sample width per channel (1..SAMPLE_BITS-1).
REQ-004 SHALL have parameter SAMPLE_RATE, default 32'd1048576, meaning the rate field written to the header.
REQ-005 SHALL have parameter FIFO_DEPTH, default 4, meaning frame FIFO depth (power of two, >=2).
REQ-006 SHALL have port clk, input, 1, meaning the single clock; all logic on rising edge.
REQ-007 SHALL have port reset_n, input, 1, meaning synchronous active-low reset.
REQ-008 SHALL have port start, input, 1, meaning a pulse that begins a stream from IDLE.
REQ-009 SHALL have port stop, input, 1, meaning a pulse that ends the stream after the current frame.
REQ-010 SHALL have port in_strobe, input, 1, meaning one frame is presented (no backpressure).
REQ-011 SHALL have port in_data, input, CHANNELS*IN_W, meaning unsigned samples, channel 0 in LSBs.
REQ-012 SHALL have port out_valid, output, 1, meaning out_data holds a valid byte.
REQ-013 SHALL have port out_ready, input, 1, meaning the sink accepts the byte this cycle.
REQ-014 SHALL have port out_data, output, 8, meaning the AU byte stream.
REQ-015 SHALL have port busy, output, 1, meaning state is not IDLE.
REQ-016 SHALL have port overrun, output, 1, meaning sticky: a frame was dropped since start.

Function
REQ-017 SHALL implement states IDLE, HEADER, DATA, DRAIN; start in IDLE moves to HEADER next cycle; start outside IDLE is ignored.
REQ-018 SHALL emit in HEADER exactly 32 bytes, big-endian: ".snd"; 0x00000020; 0xFFFFFFFF; encoding 0x00000002 (SAMPLE_BITS=8) or 0x00000003 (16); SAMPLE_RATE; CHANNELS; eight 0x00.
REQ-019 SHALL assert out_valid with byte 0 (0x2E) in the first cycle of HEADER.
REQ-020 SHALL hold out_data and out_valid stable while out_valid=1 and out_ready=0; a byte advances only on out_valid&&out_ready.
REQ-021 SHALL enter DATA after header byte 31 handshakes.
REQ-022 SHALL convert each sample s to signed {1'b0, s, zeros} of SAMPLE_BITS (s left-justified below the sign bit).
REQ-023 SHALL emit each frame as channel 0..CHANNELS-1, each sample MSB byte first; SAMPLE_BITS/8 bytes per sample.
REQ-024 SHALL assert out_valid in DATA only when a frame is in the FIFO or partially emitted; frames are popped when their last byte handshakes.
REQ-025 SHALL push a frame when in_strobe=1, state is HEADER or DATA, and FIFO not full at the start of that cycle; a pop in the same cycle does not free a slot for that push.
REQ-026 SHALL drop the frame and set overrun when in_strobe=1 in HEADER/DATA with FIFO full; in_strobe in IDLE/DRAIN is ignored without setting overrun.
REQ-027 SHALL on stop in HEADER or DATA go to DRAIN; DRAIN finishes the byte-sequence of the frame in progress (or remaining header bytes), then empties the FIFO and returns to IDLE.
REQ-028 SHALL clear overrun and the FIFO on the IDLE->HEADER transition.
REQ-029 SHALL give start priority only in IDLE and stop priority over in_strobe in the same cycle.

Reset
REQ-030 SHALL on reset_n=0 at a clock edge: state IDLE, FIFO empty, byte counters 0, out_valid=0, out_data=0x00, busy=0, overrun=0, regardless of a transfer in progress.

Configuration
REQ-031 SHALL, when SND_AU_DROP_CNT_EN is defined, add output drop_count (16 bits, reset 0, cleared on IDLE->HEADER, +1 per dropped frame, saturating at 0xFFFF).
REQ-032 SHALL, when SND_AU_DROP_CNT_EN is not defined, have no drop_count port and identical remaining behaviour.

Verification
REQ-033 SHALL cover: CHANNELS=1, SAMPLE_BITS=8, SAMPLE_RATE=8000, start, out_ready=1 -> 32 bytes 2E 73 6E 64 00 00 00 20 FF FF FF FF 00 00 00 02 00 00 1F 40 00 00 00 01 then 8x00.
REQ-034 SHALL cover: CHANNELS=2, SAMPLE_BITS=16, IN_W=4, in_data=8'hA5 after header -> bytes 28 00 50 00 (ch0=5, ch1=A).
REQ-035 SHALL cover: out_ready=0 for 5 cycles mid-header -> out_data stable, no byte skipped or repeated.
REQ-036 SHALL cover: FIFO_DEPTH=4, out_ready=0, 6 strobes in DATA -> 4 frames stored, overrun=1, drop_count=2 (macro defined).
REQ-037 SHALL cover: stop after 1st of 4 bytes of a frame -> remaining 3 bytes emitted, then busy=0 and out_valid=0.
REQ-038 SHALL cover: reset_n=0 during DATA with queued frames -> next cycle out_valid=0, busy=0; new start emits 0x2E first.

Source files
------------

// File: rtl/snd_au_stream.sv
// Sun/NeXT AU (.snd) byte-stream generator: 32-byte header, then PCM frames from a small FIFO.
// Optional SND_AU_DROP_CNT_EN adds a saturating 16-bit dropped-frame counter output.
module snd_au_stream #(
    parameter int          CHANNELS    = 2,
    parameter int          SAMPLE_BITS = 16,
    parameter int          IN_W        = 4,
    parameter logic [31:0] SAMPLE_RATE = 32'd1048576,
    parameter int          FIFO_DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     in_strobe,
    input  logic [CHANNELS*IN_W-1:0] in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [7:0]               out_data,
    output logic                     busy,
`ifdef SND_AU_DROP_CNT_EN
    output logic [15:0]              drop_count,
`endif
    output logic                     overrun
);
    localparam int BPS         = SAMPLE_BITS / 8;
    localparam int FRAME_BYTES = CHANNELS * BPS;
    localparam int DW          = CHANNELS * IN_W;
    localparam int AW          = $clog2(FIFO_DEPTH);
    localparam int PAD         = SAMPLE_BITS - 1 - IN_W;
    localparam logic [31:0]  ENC = (SAMPLE_BITS == 8) ? 32'd2 : 32'd3;
    localparam logic [255:0] HDR = {32'h2E736E64, 32'h00000020, 32'hFFFFFFFF, ENC,
                                    SAMPLE_RATE, 32'(CHANNELS), 64'h0};

    typedef enum logic [1:0] {IDLE, HEADER, DATA, DRAIN} state_t;

    state_t             r_state, w_next;
    logic [4:0]         r_hcnt, r_bcnt;
    logic [DW-1:0]      r_mem [FIFO_DEPTH];
    logic [AW:0]        r_wptr, r_rptr;
    logic               r_overrun;
    logic               r_drain_hdr;   // DRAIN still owes header bytes
    logic               r_drain_frm;   // DRAIN still owes the rest of the head frame
`ifdef SND_AU_DROP_CNT_EN
    logic [15:0]        r_drop_cnt;
`endif

    logic               w_empty, w_full, w_active, w_push, w_drop, w_pop, w_hs;
    logic               w_hdr_last, w_frm_last, w_frm_phase;
    logic [DW-1:0]      w_head;
    logic [IN_W-1:0]    w_samp;
    logic [SAMPLE_BITS-1:0] w_conv;
    logic [7:0]         w_hdr_byte, w_frm_byte;
    int                 w_ch, w_k;

    assign w_empty    = (r_wptr == r_rptr);
    assign w_full     = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_active   = ((r_state == HEADER) || (r_state == DATA)) && !stop;
    assign w_push     = in_strobe && w_active && !w_full;
    assign w_drop     = in_strobe && w_active && w_full;
    assign w_hdr_last = (r_hcnt == 5'd31);
    assign w_frm_last = (r_bcnt == 5'(FRAME_BYTES - 1));
    assign w_frm_phase = (r_state == DATA) || ((r_state == DRAIN) && !r_drain_hdr);
    assign w_hs       = out_valid && out_ready;
    assign w_pop      = w_hs && w_frm_last && w_frm_phase;
    assign w_head     = r_mem[r_rptr[AW-1:0]];
    assign w_hdr_byte = HDR[8*(31 - int'(r_hcnt)) +: 8];
    assign busy       = (r_state != IDLE);
    assign overrun    = r_overrun;
`ifdef SND_AU_DROP_CNT_EN
    assign drop_count = r_drop_cnt;
`endif

    // Sample sits just below the sign bit, zero-filled underneath.
    always_comb begin
        w_ch       = int'(r_bcnt) / BPS;
        w_k        = int'(r_bcnt) % BPS;
        w_samp     = w_head[w_ch*IN_W +: IN_W];
        w_conv     = SAMPLE_BITS'(w_samp) << PAD;
        w_frm_byte = 8'(w_conv >> (8 * (BPS - 1 - w_k)));
    end

    always_comb begin
        out_valid = 1'b0;
        out_data  = 8'h00;
        case (r_state)
            HEADER: begin
                out_valid = 1'b1;
                out_data  = w_hdr_byte;
            end
            DATA: if (!w_empty) begin
                out_valid = 1'b1;
                out_data  = w_frm_byte;
            end
            DRAIN: if (r_drain_hdr) begin
                out_valid = 1'b1;
                out_data  = w_hdr_byte;
            end else if (r_drain_frm) begin
                out_valid = 1'b1;
                out_data  = w_frm_byte;
            end
            default: ;
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:   if (start) w_next = HEADER;
            HEADER: if (stop) w_next = DRAIN;
                    else if (w_hs && w_hdr_last) w_next = DATA;
            DATA:   if (stop) w_next = DRAIN;
            DRAIN:  if (r_drain_hdr) begin
                        if (w_hs && w_hdr_last) w_next = IDLE;
                    end else if (r_drain_frm) begin
                        if (w_hs && w_frm_last) w_next = IDLE;
                    end else begin
                        w_next = IDLE;
                    end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr[AW-1:0]] <= in_data;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_hcnt      <= '0;
            r_bcnt      <= '0;
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_overrun   <= 1'b0;
            r_drain_hdr <= 1'b0;
            r_drain_frm <= 1'b0;
`ifdef SND_AU_DROP_CNT_EN
            r_drop_cnt  <= '0;
`endif
        end else begin
            r_state <= w_next;
            if ((r_state == IDLE) && start) begin
                r_hcnt      <= '0;
                r_bcnt      <= '0;
                r_wptr      <= '0;
                r_rptr      <= '0;
                r_overrun   <= 1'b0;
                r_drain_hdr <= 1'b0;
                r_drain_frm <= 1'b0;
`ifdef SND_AU_DROP_CNT_EN
                r_drop_cnt  <= '0;
`endif
            end else begin
                if (w_hs && ((r_state == HEADER) || ((r_state == DRAIN) && r_drain_hdr)))
                    r_hcnt <= r_hcnt + 5'd1;
                if (w_hs && w_frm_phase)
                    r_bcnt <= w_frm_last ? 5'd0 : r_bcnt + 5'd1;
                if (w_push) r_wptr <= r_wptr + 1'b1;
                if (w_pop)  r_rptr <= r_rptr + 1'b1;
                if (w_drop) begin
                    r_overrun <= 1'b1;
`ifdef SND_AU_DROP_CNT_EN
                    if (r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
`endif
                end
                if (stop && (r_state == HEADER)) begin
                    r_drain_hdr <= !(w_hs && w_hdr_last);
                    r_drain_frm <= 1'b0;
                end
                if (stop && (r_state == DATA)) begin
                    r_drain_hdr <= 1'b0;
                    r_drain_frm <= !w_empty && !w_pop;
                end
                // Leaving DRAIN discards whatever frames are still queued.
                if ((r_state == DRAIN) && (w_next == IDLE)) begin
                    r_wptr      <= '0;
                    r_rptr      <= '0;
                    r_hcnt      <= '0;
                    r_bcnt      <= '0;
                    r_drain_hdr <= 1'b0;
                    r_drain_frm <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_snd_au_stream.sv
// Bench for snd_au_stream: header table on an 8-bit mono build, scoreboard model on a 16-bit stereo build.
module tb_snd_au_stream;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Instance A: CHANNELS=1, SAMPLE_BITS=8, SAMPLE_RATE=8000
    logic       a_start = 1'b0, a_stop = 1'b0, a_strobe = 1'b0, a_ready = 1'b0;
    logic [4:0] a_in = '0;
    logic       a_valid, a_busy, a_ovr;
    logic [7:0] a_data;
    // Instance B: defaults
    logic       start = 1'b0, stop = 1'b0, in_strobe = 1'b0, out_ready = 1'b0;
    logic [7:0] in_data = '0;
    logic       out_valid, busy, overrun;
    logic [7:0] out_data;
`ifdef SND_AU_DROP_CNT_EN
    logic [15:0] a_drop, drop_count;
`endif

    snd_au_stream #(.CHANNELS(1), .SAMPLE_BITS(8), .IN_W(5), .SAMPLE_RATE(32'd8000), .FIFO_DEPTH(4)) u_a (
        .clk(clk), .reset_n(rst_n), .start(a_start), .stop(a_stop), .in_strobe(a_strobe),
        .in_data(a_in), .out_valid(a_valid), .out_ready(a_ready), .out_data(a_data), .busy(a_busy),
`ifdef SND_AU_DROP_CNT_EN
        .drop_count(a_drop),
`endif
        .overrun(a_ovr));

    snd_au_stream #(.CHANNELS(2), .SAMPLE_BITS(16), .IN_W(4), .SAMPLE_RATE(32'd1048576), .FIFO_DEPTH(4)) u_b (
        .clk(clk), .reset_n(rst_n), .start(start), .stop(stop), .in_strobe(in_strobe),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy),
`ifdef SND_AU_DROP_CNT_EN
        .drop_count(drop_count),
`endif
        .overrun(overrun));

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // ---------------- reference model for instance B ----------------
    logic [7:0]  hdr_b [32];
    logic [31:0] m_q [$];
    logic [7:0]  got [$];
    int m_st, m_hpos, m_pos, m_drops;   // m_st: 0 idle, 1 header, 2 data, 3 drain
    bit m_ovr, m_dh, m_df;

    function automatic logic [7:0] fbyte(input logic [31:0] f, input int i);
        return f[8*(3-i) +: 8];
    endfunction

    task automatic m_idle();
        m_st = 0; m_hpos = 0; m_pos = 0; m_dh = 0; m_df = 0;
        m_q.delete();
    endtask

    task automatic m_strobe(input logic [7:0] d, input bit full);
        logic [15:0] c0, c1;
        if (full) begin
            m_ovr = 1; m_drops++;
        end else begin
            c0 = 16'(d[3:0]) << 11;
            c1 = 16'(d[7:4]) << 11;
            m_q.push_back({c0, c1});
        end
    endtask

    task automatic step(input bit st, input bit sp, input bit sb, input logic [7:0] d, input bit rd);
        bit ev, hs, full;
        logic [7:0] ed;
        start = st; stop = sp; in_strobe = sb; in_data = d; out_ready = rd;
        ev = 0; ed = 8'h00;
        case (m_st)
            1: begin ev = 1; ed = hdr_b[m_hpos]; end
            2: if (m_q.size() > 0) begin ev = 1; ed = fbyte(m_q[0], m_pos); end
            3: if (m_dh) begin ev = 1; ed = hdr_b[m_hpos]; end
               else if (m_df) begin ev = 1; ed = fbyte(m_q[0], m_pos); end
            default: ;
        endcase
        chk("out_valid", out_valid, ev);
        if (ev) chk("out_data", out_data, ed);
        chk("busy", busy, m_st != 0);
        chk("overrun", overrun, m_ovr);
`ifdef SND_AU_DROP_CNT_EN
        chk("drop_count", drop_count, m_drops);
`endif
        hs = ev && rd;
        if (hs) got.push_back(out_data);
        full = (m_q.size() >= 4);
        case (m_st)
            0: if (st) begin
                m_idle(); m_st = 1; m_ovr = 0; m_drops = 0;
            end
            1: if (sp) begin
                m_st = 3; m_dh = !(hs && m_hpos == 31); m_df = 0;
                if (hs) m_hpos++;
            end else begin
                if (sb) m_strobe(d, full);
                if (hs) begin
                    if (m_hpos == 31) begin m_st = 2; m_hpos = 0; end
                    else m_hpos++;
                end
            end
            2: begin
                if (sp) begin
                    m_st = 3; m_dh = 0;
                    m_df = (m_q.size() > 0) && !(hs && m_pos == 3);
                end else if (sb) m_strobe(d, full);
                if (hs) begin
                    if (m_pos == 3) begin void'(m_q.pop_front()); m_pos = 0; end
                    else m_pos++;
                end
            end
            3: if (m_dh) begin
                if (hs) begin
                    if (m_hpos == 31) m_idle(); else m_hpos++;
                end
            end else if (m_df) begin
                if (hs) begin
                    if (m_pos == 3) m_idle(); else m_pos++;
                end
            end else m_idle();
            default: ;
        endcase
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        start = 0; stop = 0; in_strobe = 0; out_ready = 0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("rst out_valid", out_valid, 0);
        chk("rst out_data", out_data, 8'h00);
        chk("rst busy", busy, 0);
        chk("rst overrun", overrun, 0);
`ifdef SND_AU_DROP_CNT_EN
        chk("rst drop_count", drop_count, 0);
`endif
        rst_n = 1'b1;
        m_idle(); m_ovr = 0; m_drops = 0;
    endtask

    task automatic run_header();
        step(1, 0, 0, 8'h00, 1);
        for (int i = 0; i < 32; i++) step(0, 0, 0, 8'h00, 1);
    endtask

    // ---------------- table for instance A header ----------------
    typedef struct { logic rdy; logic exp_v; logic [7:0] exp_d; } vec_t;
    vec_t tbl [$];
    logic [7:0] a_hdr [32] = '{8'h2E, 8'h73, 8'h6E, 8'h64, 8'h00, 8'h00, 8'h00, 8'h20,
                               8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h02,
                               8'h00, 8'h00, 8'h1F, 8'h40, 8'h00, 8'h00, 8'h00, 8'h01,
                               8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

    initial begin
        logic [255:0] h;
        h = {32'h2E736E64, 32'h20, 32'hFFFFFFFF, 32'd3, 32'd1048576, 32'd2, 64'h0};
        for (int i = 0; i < 32; i++) hdr_b[i] = h[8*(31-i) +: 8];
        for (int i = 0; i < 32; i++) begin
            if (i == 12) for (int s = 0; s < 5; s++) tbl.push_back('{1'b0, 1'b1, a_hdr[i]});
            tbl.push_back('{1'b1, 1'b1, a_hdr[i]});
        end
        tbl.push_back('{1'b1, 1'b0, 8'h00});

        do_reset();
        chk("A rst valid", a_valid, 0);
        chk("A rst busy", a_busy, 0);

        // Instance A: header bytes, with a 5-cycle stall mid-header
        a_start = 1; @(posedge clk); #1; a_start = 0;
        foreach (tbl[i]) begin
            a_ready = tbl[i].rdy;
            chk("A valid", a_valid, tbl[i].exp_v);
            if (tbl[i].exp_v) chk($sformatf("A hdr[%0d]", i), a_data, tbl[i].exp_d);
            @(posedge clk); #1;
        end
        chk("A busy", a_busy, 1);
        a_ready = 0;

        // One stereo frame 0xA5 -> 28 00 50 00
        run_header();
        got.delete();
        step(0, 0, 1, 8'hA5, 1);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 8'h00, 1);
        chk("A5 nbytes", got.size(), 4);
        if (got.size() == 4) begin
            chk("A5 b0", got[0], 8'h28); chk("A5 b1", got[1], 8'h00);
            chk("A5 b2", got[2], 8'h50); chk("A5 b3", got[3], 8'h00);
        end

        // Six strobes into a stalled depth-4 FIFO: two drops
        for (int i = 0; i < 6; i++) step(0, 0, 1, 8'(8'h11 * (i + 1)), 0);
        chk("ovr sticky", overrun, 1);
`ifdef SND_AU_DROP_CNT_EN
        chk("drop_count=2", drop_count, 16'd2);
`endif
        got.delete();
        for (int i = 0; i < 18; i++) step(0, 0, 0, 8'h00, 1);
        chk("stored bytes", got.size(), 16);

        // Stop after first byte of a frame: finish remaining 3 bytes, then idle
        got.delete();
        step(0, 0, 1, 8'h3C, 0);
        step(0, 0, 0, 8'h00, 1);
        step(0, 1, 0, 8'h00, 1);
        step(0, 0, 0, 8'h00, 1);
        step(0, 0, 0, 8'h00, 1);
        chk("stop nbytes", got.size(), 4);
        chk("stop busy", busy, 0);
        chk("stop valid", out_valid, 0);

        // Reset in DATA with queued frames, then restart
        run_header();
        for (int i = 0; i < 3; i++) step(0, 0, 1, 8'($urandom), 0);
        do_reset();
        step(1, 0, 0, 8'h00, 0);
        chk("restart valid", out_valid, 1);
        chk("restart byte0", out_data, 8'h2E);

        // Randomized traffic against the model
        for (int e = 0; e < 5; e++) begin
            for (int c = 0; c < 400; c++)
                step($urandom_range(0, 19) == 0, $urandom_range(0, 79) == 0,
                     $urandom_range(0, 2) == 0, 8'($urandom), $urandom_range(0, 3) != 0);
            do_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
